// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS subset datapath.
// Sequences each instruction through IF/ID/EXE/MEM/WB, decodes opcode/funct
// held in the instruction register, and drives the ALU operation, datapath
// mux selects and the PC/IR/register-file/data-memory write enables.
// The FSM state is the only control state; every control output is decoded
// combinationally from state, opcode, funct and zero. All write enables are
// gated by rst so that an asynchronous reset kills any write at once.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [4:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegDst,
    output logic             WDSel,
    output logic [1:0]       NPCOp,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    // ALU operation encodings shared with the datapath ALU.
    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADDU = 5'd1;
    localparam logic [4:0] ALUOP_ADD  = 5'd2;
    localparam logic [4:0] ALUOP_SUBU = 5'd3;
    localparam logic [4:0] ALUOP_SUB  = 5'd4;
    localparam logic [4:0] ALUOP_OR   = 5'd5;
    localparam logic [4:0] ALUOP_SLT  = 5'd6;
    localparam logic [4:0] ALUOP_LUI  = 5'd7;
    localparam logic [4:0] ALUOP_EQL  = 5'd8;
    localparam logic [4:0] ALUOP_BNE  = 5'd9;

    // Opcode field values.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Funct field values for R-type.
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // ALUSrcB selections.
    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    // NPCOp selections.
    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_next;

    logic is_rtype;
    logic is_ialu;
    logic is_lw;
    logic is_sw;
    logic is_branch;
    logic is_jump;
    logic legal;
    logic [4:0] exe_op;
    logic [1:0] exe_srcb;

    logic pc_we;
    logic ir_we;
    logic rf_we;
    logic mem_we;
    logic ill_pulse;
    logic retire_now;

    // Instruction decode: classify the IR contents and work out the ALU
    // operation and B-operand source this instruction uses in EXE.
    always_comb begin
        is_rtype  = 1'b0;
        is_ialu   = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        exe_op    = ALUOP_NOP;
        exe_srcb  = SRCB_REG;
        case (opcode)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                exe_srcb = SRCB_REG;
                case (funct)
                    FN_ADDU: exe_op = ALUOP_ADDU;
                    FN_SUBU: exe_op = ALUOP_SUBU;
                    FN_ADD:  exe_op = ALUOP_ADD;
                    FN_SUB:  exe_op = ALUOP_SUB;
                    FN_OR:   exe_op = ALUOP_OR;
                    FN_SLT:  exe_op = ALUOP_SLT;
                    default: begin
                        is_rtype = 1'b0;
                        exe_op   = ALUOP_NOP;
                    end
                endcase
            end
            OP_ADDI: begin
                is_ialu  = 1'b1;
                exe_op   = ALUOP_ADD;
                exe_srcb = SRCB_SEXT;
            end
            OP_ORI: begin
                is_ialu  = 1'b1;
                exe_op   = ALUOP_OR;
                exe_srcb = SRCB_ZEXT;
            end
            OP_LUI: begin
                is_ialu  = 1'b1;
                exe_op   = ALUOP_LUI;
                exe_srcb = SRCB_SEXT;
            end
            OP_LW: begin
                is_lw    = 1'b1;
                exe_op   = ALUOP_ADDU;
                exe_srcb = SRCB_SEXT;
            end
            OP_SW: begin
                is_sw    = 1'b1;
                exe_op   = ALUOP_ADDU;
                exe_srcb = SRCB_SEXT;
            end
            OP_BEQ: begin
                is_branch = 1'b1;
                exe_op    = ALUOP_EQL;
                exe_srcb  = SRCB_REG;
            end
            OP_BNE: begin
                is_branch = 1'b1;
                exe_op    = ALUOP_BNE;
                exe_srcb  = SRCB_REG;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            default: begin
                exe_op = ALUOP_NOP;
            end
        endcase
        legal = is_rtype | is_ialu | is_lw | is_sw | is_branch | is_jump;
    end

    // Per-state control decode and next-state selection. Outside IF the ALU
    // keeps the instruction's EXE operation so ALUOut is never disturbed.
    always_comb begin
        state_next = S_IF;
        ALUOp      = exe_op;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        RegDst     = 1'b0;
        WDSel      = 1'b0;
        NPCOp      = NPC_PLUS4;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        mem_we     = 1'b0;
        ill_pulse  = 1'b0;
        retire_now = 1'b0;
        case (state_q)
            S_IF: begin
                ALUOp      = ALUOP_ADDU;
                ALUSrcA    = 1'b0;
                ALUSrcB    = SRCB_FOUR;
                NPCOp      = NPC_PLUS4;
                pc_we      = 1'b1;
                ir_we      = 1'b1;
                state_next = S_ID;
            end
            S_ID: begin
                if (is_jump) begin
                    pc_we      = 1'b1;
                    NPCOp      = NPC_JUMP;
                    retire_now = 1'b1;
                    state_next = S_IF;
                end else if (!legal) begin
                    ill_pulse  = 1'b1;
                    ALUOp      = ALUOP_NOP;
                    state_next = S_IF;
                end else begin
                    state_next = S_EXE;
                end
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = exe_srcb;
                if (is_branch) begin
                    NPCOp      = NPC_BRANCH;
                    pc_we      = zero;
                    retire_now = 1'b1;
                    state_next = S_IF;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else if (legal) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_IF;
                end
            end
            S_MEM: begin
                ALUSrcA = 1'b1;
                ALUSrcB = exe_srcb;
                if (is_sw) begin
                    mem_we     = 1'b1;
                    retire_now = 1'b1;
                    state_next = S_IF;
                end else if (is_lw) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_IF;
                end
            end
            S_WB: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = exe_srcb;
                rf_we      = 1'b1;
                RegDst     = is_rtype;
                WDSel      = is_lw;
                retire_now = 1'b1;
                state_next = S_IF;
            end
            default: begin
                ALUOp      = ALUOP_NOP;
                state_next = S_IF;
            end
        endcase
    end

    // Gate every write enable and the illegal pulse with reset so an
    // asynchronous reset aborts the instruction without partial writes.
    always_comb begin
        PCWrite  = pc_we & ~rst;
        IRWrite  = ir_we & ~rst;
        RegWrite = rf_we & ~rst;
        MemWrite = mem_we & ~rst;
        illegal  = ill_pulse & ~rst;
    end

    assign state = state_q;

    // State register of the instruction sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_next;
        end
    end

    // Retired-instruction counter, bumped on the transition back to IF
    // after a legal instruction completes; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire_now) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each issued instruction pushes its
// expected per-cycle control pattern; a monitor pops and compares each cycle.
// A second instance with a 2-bit counter shares the stimulus to show wrap.
module tb_multicycle_ctrl;

    localparam logic [4:0] A_NOP  = 5'd0;
    localparam logic [4:0] A_ADDU = 5'd1;
    localparam logic [4:0] A_ADD  = 5'd2;
    localparam logic [4:0] A_SUBU = 5'd3;
    localparam logic [4:0] A_SUB  = 5'd4;
    localparam logic [4:0] A_OR   = 5'd5;
    localparam logic [4:0] A_SLT  = 5'd6;
    localparam logic [4:0] A_LUI  = 5'd7;
    localparam logic [4:0] A_EQL  = 5'd8;
    localparam logic [4:0] A_BNE  = 5'd9;

    typedef enum int {K_RT, K_IALU, K_LW, K_SW, K_BR, K_J, K_ILL} kind_e;

    typedef struct {
        logic [19:0] val;
        logic [19:0] care;
        logic [31:0] ret;
        logic [1:0]  ret_s;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic [4:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        RegDst;
    logic        WDSel;
    logic [1:0]  NPCOp;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    logic [4:0]  s_ALUOp;
    logic        s_ALUSrcA;
    logic [1:0]  s_ALUSrcB;
    logic        s_RegDst;
    logic        s_WDSel;
    logic [1:0]  s_NPCOp;
    logic        s_PCWrite;
    logic        s_IRWrite;
    logic        s_RegWrite;
    logic        s_MemWrite;
    logic        s_illegal;
    logic [2:0]  s_state;
    logic [1:0]  retired_s;

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];
    logic [31:0] model_count = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
        .WDSel(WDSel), .NPCOp(NPCOp), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal(illegal),
        .state(state), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .ALUOp(s_ALUOp), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .RegDst(s_RegDst),
        .WDSel(s_WDSel), .NPCOp(s_NPCOp), .PCWrite(s_PCWrite), .IRWrite(s_IRWrite),
        .RegWrite(s_RegWrite), .MemWrite(s_MemWrite), .illegal(s_illegal),
        .state(s_state), .retired(retired_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs the observed or expected control fields into one comparable word.
    function automatic logic [19:0] pack(input logic [2:0] s, input logic [4:0] a,
                                         input logic pcw, input logic irw, input logic rw,
                                         input logic mw, input logic ill, input logic [1:0] npc,
                                         input logic rd, input logic wd, input logic sa,
                                         input logic [1:0] sbv);
        return {s, a, pcw, irw, rw, mw, ill, npc, rd, wd, sa, sbv};
    endfunction

    // Reference decode: instruction class, EXE ALU op and B-source.
    function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                     output kind_e k, output logic [4:0] aop,
                                     output logic [1:0] sbv);
        k = K_ILL; aop = A_NOP; sbv = 2'd0;
        case (op)
            6'b000000: begin
                k = K_RT;
                case (fn)
                    6'b100001: aop = A_ADDU;
                    6'b100011: aop = A_SUBU;
                    6'b100000: aop = A_ADD;
                    6'b100010: aop = A_SUB;
                    6'b100101: aop = A_OR;
                    6'b101010: aop = A_SLT;
                    default:   k = K_ILL;
                endcase
            end
            6'b001000: begin k = K_IALU; aop = A_ADD;  sbv = 2'd2; end
            6'b001101: begin k = K_IALU; aop = A_OR;   sbv = 2'd3; end
            6'b001111: begin k = K_IALU; aop = A_LUI;  sbv = 2'd2; end
            6'b100011: begin k = K_LW;   aop = A_ADDU; sbv = 2'd2; end
            6'b101011: begin k = K_SW;   aop = A_ADDU; sbv = 2'd2; end
            6'b000100: begin k = K_BR;   aop = A_EQL;  end
            6'b000101: begin k = K_BR;   aop = A_BNE;  end
            6'b000010: begin k = K_J; end
            default:   k = K_ILL;
        endcase
    endfunction

    // Issues one instruction from an IF cycle, queues its expected cycles,
    // then waits out its latency so the next call again starts in IF.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        kind_e k;
        logic [4:0] aop;
        logic [1:0] sbv;
        int phases[$];
        exp_t e;
        classify(op, fn, k, aop, sbv);
        case (k)
            K_J, K_ILL:     phases = '{0, 1};
            K_BR:           phases = '{0, 1, 2};
            K_RT, K_IALU:   phases = '{0, 1, 2, 4};
            K_SW:           phases = '{0, 1, 2, 3};
            default:        phases = '{0, 1, 2, 3, 4};
        endcase
        opcode = op;
        funct  = fn;
        zero   = z;
        foreach (phases[i]) begin
            e.ret   = model_count;
            e.ret_s = model_count[1:0];
            $sformat(e.tag, "op%b_fn%b_st%0d", op, fn, phases[i]);
            case (phases[i])
                0: begin
                    e.val  = pack(3'd0, A_ADDU, 1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd1);
                    e.care = pack(3'h7, 5'h1f, 1, 1, 1, 1, 1, 2'h3, 0, 0, 1, 2'h3);
                end
                1: begin
                    e.val  = pack(3'd1, aop, k == K_J, 0, 0, 0, k == K_ILL,
                                  (k == K_J) ? 2'd2 : 2'd0, 0, 0, 0, 2'd0);
                    e.care = pack(3'h7, (k == K_J || k == K_ILL) ? 5'h0 : 5'h1f,
                                  1, 1, 1, 1, 1, (k == K_J) ? 2'h3 : 2'h0, 0, 0, 0, 2'h0);
                end
                2: begin
                    e.val  = pack(3'd2, aop, (k == K_BR) ? z : 1'b0, 0, 0, 0, 0,
                                  2'd1, 0, 0, 1, sbv);
                    e.care = pack(3'h7, 5'h1f, 1, 1, 1, 1, 1,
                                  (k == K_BR) ? 2'h3 : 2'h0, 0, 0, 1, 2'h3);
                end
                3: begin
                    e.val  = pack(3'd3, aop, 0, 0, 0, k == K_SW, 0, 2'd0, 0, 0, 0, 2'd0);
                    e.care = pack(3'h7, 5'h1f, 1, 1, 1, 1, 1, 2'h0, 0, 0, 0, 2'h0);
                end
                default: begin
                    e.val  = pack(3'd4, aop, 0, 0, 1, 0, 0, 2'd0, k == K_RT, k == K_LW, 0, 2'd0);
                    e.care = pack(3'h7, 5'h1f, 1, 1, 1, 1, 1, 2'h0, 1, 1, 0, 2'h0);
                end
            endcase
            sb_q.push_back(e);
        end
        if (k != K_ILL) model_count = model_count + 32'd1;
        repeat (phases.size()) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every non-reset cycle against the queued expectation.
    initial begin
        exp_t e;
        logic [19:0] act;
        forever begin
            @(negedge clk);
            if (!rst && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = pack(state, ALUOp, PCWrite, IRWrite, RegWrite, MemWrite, illegal,
                           NPCOp, RegDst, WDSel, ALUSrcA, ALUSrcB);
                total++;
                if ((act & e.care) !== (e.val & e.care)) begin
                    bad++;
                    $display("[TB] FAIL ctrl %s: got %h expected %h (care %h)",
                             e.tag, act, e.val, e.care);
                end
                total++;
                if (retired !== e.ret || retired_s !== e.ret_s) begin
                    bad++;
                    $display("[TB] FAIL retired %s: got %h/%h expected %h/%h",
                             e.tag, retired, retired_s, e.ret, e.ret_s);
                end
            end
        end
    end

    initial begin
        logic [5:0] op_tab[14];
        logic [5:0] fn_tab[6];
        int idx;
        op_tab = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                   6'b001000, 6'b001101, 6'b001111, 6'b100011, 6'b101011,
                   6'b000100, 6'b000101, 6'b000010};
        fn_tab = '{6'b100001, 6'b100011, 6'b100000, 6'b100010, 6'b100101, 6'b101010};
        rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_retired", retired, 32'd0);
        checkOutput("reset_enables", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, illegal}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(6'b000000, 6'b100001, 1'b0);
        applyStimulus(6'b100011, 6'b000000, 1'b0);
        applyStimulus(6'b000100, 6'b000000, 1'b1);
        applyStimulus(6'b000100, 6'b000000, 1'b0);
        applyStimulus(6'b000101, 6'b000000, 1'b1);
        applyStimulus(6'b101011, 6'b000000, 1'b0);
        applyStimulus(6'b111111, 6'b000000, 1'b0);
        applyStimulus(6'b000000, 6'b000000, 1'b0);
        applyStimulus(6'b000010, 6'b000000, 1'b0);

        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, 15);
            if (idx < 6)
                applyStimulus(op_tab[idx], fn_tab[idx], 1'($urandom_range(0, 1)));
            else if (idx < 14)
                applyStimulus(op_tab[idx], 6'($urandom), 1'($urandom_range(0, 1)));
            else if (idx == 14)
                applyStimulus(6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
            else
                applyStimulus(6'b000000, 6'($urandom), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the WB cycle of an addu.
        opcode = 6'b000000; funct = 6'b100001; zero = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("wb_regwrite_before_rst", 32'(RegWrite), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_retired_small", 32'(retired_s), 32'd0);
        checkOutput("rst_pc_ir_write", {30'd0, PCWrite, IRWrite}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_count = 0;

        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 13);
            applyStimulus(op_tab[idx], (idx < 6) ? fn_tab[idx] : 6'($urandom),
                          1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 5; n++) applyStimulus(6'b000010, 6'd0, 1'b0);

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
